confirm_input_ctrl: RTL and testbench

//  Front-end for the board inputs feeding the CPU top: confirm button, 16 value switches, 3 test-select switches.

---
 rtl/confirm_input_ctrl.sv | 129 ++++++++++++
 tb/tb_confirm_input_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/confirm_input_ctrl.sv
// Board input front-end: synchronises the switches and button, debounces the confirm button,
// and issues one accept strobe with a latched switch snapshot per press during an input ecall.
module confirm_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 230000,
  parameter int CNT_WIDTH       = 18,
  parameter int SW_WIDTH        = 16,
  parameter int TC_WIDTH        = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                button_raw,
  input  logic [SW_WIDTH-1:0] switch_raw,
  input  logic [TC_WIDTH-1:0] test_raw,
  input  logic                wait_req,
  output logic                confirm_pulse,
  output logic [SW_WIDTH-1:0] switch_value,
  output logic [TC_WIDTH-1:0] test_value,
  output logic                waiting_led,
  output logic                btn_level
);

  // state  | meaning
  // IDLE   | no input request pending, button released
  // ARMED  | CPU waiting for input, button released, LED on
  // ACCEPT | single-cycle strobe, snapshot loads on this edge
  // HELD   | button down, waiting for release before re-arming
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACCEPT = 2'd2,
    ST_HELD   = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [1:0]          r_btn_sync;
  logic [SW_WIDTH-1:0] r_sw_s1;
  logic [SW_WIDTH-1:0] r_sw_s2;
  logic [TC_WIDTH-1:0] r_tc_s1;
  logic [TC_WIDTH-1:0] r_tc_s2;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                r_btn_level;
  logic [SW_WIDTH-1:0] r_switch_value;
  logic [TC_WIDTH-1:0] r_test_value;
  state_t              r_state;
  state_t              w_next_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_btn_sync     <= '0;
      r_sw_s1        <= '0;
      r_sw_s2        <= '0;
      r_tc_s1        <= '0;
      r_tc_s2        <= '0;
      r_cnt          <= '0;
      r_btn_level    <= 1'b0;
      r_switch_value <= '0;
      r_test_value   <= '0;
    end else begin
      r_btn_sync <= {r_btn_sync[0], button_raw};
      r_sw_s1    <= switch_raw;
      r_sw_s2    <= r_sw_s1;
      r_tc_s1    <= test_raw;
      r_tc_s2    <= r_tc_s1;

      // Any cycle agreeing with the accepted level restarts the stability window.
      if (r_btn_sync[1] == r_btn_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_btn_level <= ~r_btn_level;
        r_cnt       <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end

      if (r_state == ST_ACCEPT) begin
        r_switch_value <= r_sw_s2;
        r_test_value   <= r_tc_s2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    confirm_pulse = 1'b0;
    waiting_led   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_btn_level) begin
          w_next_state = ST_HELD;
        end else if (wait_req) begin
          w_next_state = ST_ARMED;
        end
      end
      ST_ARMED: begin
        waiting_led = 1'b1;
        // Dropping the request wins over a simultaneous press.
        if (!wait_req) begin
          w_next_state = ST_IDLE;
        end else if (r_btn_level) begin
          w_next_state = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        confirm_pulse = !reset;
        w_next_state  = ST_HELD;
      end
      ST_HELD: begin
        if (!r_btn_level) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign switch_value = r_switch_value;
  assign test_value   = r_test_value;
  assign btn_level    = r_btn_level;

endmodule

// File: tb/tb_confirm_input_ctrl.sv
// Directed bench for confirm_input_ctrl with a short debounce window; accepted presses
// are predicted into a queue and matched against each confirm_pulse and its snapshot.
module tb_confirm_input_ctrl;

  localparam int DEB = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        button_raw;
  logic [15:0] switch_raw;
  logic [2:0]  test_raw;
  logic        wait_req;
  logic        confirm_pulse;
  logic [15:0] switch_value;
  logic [2:0]  test_value;
  logic        waiting_led;
  logic        btn_level;

  typedef struct packed {
    logic [15:0] sw;
    logic [2:0]  tc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pcnt = 0;
  int   pulse_cnt = 0;
  int   last_pulse = -1;
  bit   prev_pulse = 1'b0;

  confirm_input_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_WIDTH      (4),
    .SW_WIDTH       (16),
    .TC_WIDTH       (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .button_raw   (button_raw),
    .switch_raw   (switch_raw),
    .test_raw     (test_raw),
    .wait_req     (wait_req),
    .confirm_pulse(confirm_pulse),
    .switch_value (switch_value),
    .test_value   (test_value),
    .waiting_led  (waiting_led),
    .btn_level    (btn_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pcnt <= pcnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: a pulse pops one prediction; the snapshot is compared the cycle after.
  always @(negedge clk) begin
    if (prev_pulse) begin
      chk("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("snap_switch", 32'(switch_value), 32'(e.sw));
        chk("snap_test", 32'(test_value), 32'(e.tc));
      end
    end
    if (confirm_pulse === 1'b1) begin
      pulse_cnt++;
      last_pulse = pcnt;
      chk("pulse_not_consecutive", 32'(prev_pulse), 32'd0);
    end
    prev_pulse = (confirm_pulse === 1'b1);
  end

  initial begin
    int base;
    int k;

    reset      = 1'b1;
    button_raw = 1'b0;
    switch_raw = '0;
    test_raw   = '0;
    wait_req   = 1'b0;
    cyc(3);
    chk("rst_pulse", 32'(confirm_pulse), 32'd0);
    chk("rst_switch", 32'(switch_value), 32'd0);
    chk("rst_test", 32'(test_value), 32'd0);
    chk("rst_led", 32'(waiting_led), 32'd0);
    chk("rst_level", 32'(btn_level), 32'd0);
    reset = 1'b0;
    cyc(2);

    // No input request: presses debounce but never accept.
    switch_raw = 16'hFFFF;
    test_raw   = 3'd7;
    base = pulse_cnt;
    for (int i = 0; i < 3; i++) begin
      button_raw = 1'b1;
      cyc(14);
      chk("noreq_level_hi", 32'(btn_level), 32'd1);
      chk("noreq_led", 32'(waiting_led), 32'd0);
      button_raw = 1'b0;
      cyc(14);
    end
    chk("noreq_pulses", 32'(pulse_cnt - base), 32'd0);
    chk("noreq_switch", 32'(switch_value), 32'd0);
    chk("noreq_test", 32'(test_value), 32'd0);

    // Clean press while armed.
    switch_raw = 16'hA5C3;
    test_raw   = 3'd5;
    wait_req   = 1'b1;
    cyc(3);
    chk("armed_led", 32'(waiting_led), 32'd1);
    exp_q.push_back('{sw: 16'hA5C3, tc: 3'd5});
    base = pulse_cnt;
    k = pcnt;
    button_raw = 1'b1;
    cyc(20);
    chk("clean_pulses", 32'(pulse_cnt - base), 32'd1);
    chk("clean_latency", 32'(last_pulse - k), 32'(DEB + 3));
    chk("held_led", 32'(waiting_led), 32'd0);
    button_raw = 1'b0;
    cyc(15);
    chk("rearm_led", 32'(waiting_led), 32'd1);

    // Snapshot holds while switches move.
    switch_raw = 16'h1234;
    test_raw   = 3'd1;
    cyc(10);
    chk("hold_switch_a", 32'(switch_value), 32'hA5C3);
    chk("hold_test_a", 32'(test_value), 32'd5);
    cyc(10);
    chk("hold_switch_b", 32'(switch_value), 32'hA5C3);
    chk("hold_test_b", 32'(test_value), 32'd5);

    // Bouncy press: accepted only after the level settles.
    exp_q.push_back('{sw: 16'h1234, tc: 3'd1});
    base = pulse_cnt;
    k = pcnt;
    for (int i = 0; i < 5; i++) begin
      button_raw = (i % 2 == 0);
      cyc(3);
    end
    cyc(20);
    chk("bounce_pulses", 32'(pulse_cnt - base), 32'd1);
    chk("bounce_latency", 32'(last_pulse - k), 32'(12 + DEB + 3));
    button_raw = 1'b0;
    cyc(15);

    // Button already down when the request arrives.
    wait_req   = 1'b0;
    switch_raw = 16'hBEEF;
    test_raw   = 3'd7;
    base = pulse_cnt;
    button_raw = 1'b1;
    cyc(14);
    wait_req = 1'b1;
    cyc(10);
    chk("predown_led", 32'(waiting_led), 32'd0);
    chk("predown_pulses", 32'(pulse_cnt - base), 32'd0);
    button_raw = 1'b0;
    cyc(15);
    chk("predown_rearm", 32'(waiting_led), 32'd1);
    exp_q.push_back('{sw: 16'hBEEF, tc: 3'd7});
    k = pcnt;
    button_raw = 1'b1;
    cyc(20);
    chk("repress_pulses", 32'(pulse_cnt - base), 32'd1);
    chk("repress_latency", 32'(last_pulse - k), 32'(DEB + 3));
    button_raw = 1'b0;
    cyc(15);

    // Request drops on the very cycle the debounced level is first seen.
    base = pulse_cnt;
    button_raw = 1'b1;
    cyc(DEB + 2);
    wait_req = 1'b0;
    cyc(10);
    chk("prio_pulses", 32'(pulse_cnt - base), 32'd0);
    chk("prio_led", 32'(waiting_led), 32'd0);
    chk("prio_level", 32'(btn_level), 32'd1);
    button_raw = 1'b0;
    cyc(15);
    wait_req = 1'b1;
    cyc(3);
    chk("prio_rearm", 32'(waiting_led), 32'd1);

    // Reset in the middle of a debounce while armed.
    base = pulse_cnt;
    button_raw = 1'b1;
    cyc(4);
    reset      = 1'b1;
    wait_req   = 1'b0;
    button_raw = 1'b0;
    cyc(1);
    chk("mid_rst_pulse", 32'(confirm_pulse), 32'd0);
    chk("mid_rst_led", 32'(waiting_led), 32'd0);
    chk("mid_rst_level", 32'(btn_level), 32'd0);
    chk("mid_rst_switch", 32'(switch_value), 32'd0);
    chk("mid_rst_test", 32'(test_value), 32'd0);
    reset = 1'b0;
    cyc(20);
    chk("post_rst_pulses", 32'(pulse_cnt - base), 32'd0);
    chk("post_rst_level", 32'(btn_level), 32'd0);

    cyc(3);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
